ad_setup_sequencer: RTL and testbench
=====================================

// Module: ad_setup_sequencer
// PURPOSE
//   Walks the 32-word A/D setup RAM from word 0 and shifts each word's 16-bit command to the A/D converter.
//   Uses a SPI mode-0 serial link and captures the converter's reply bits.
//   Sits between the setup RAM read port (registered address, 1-cycle read latency) and the A/D pins.
//   The CPU writes the RAM, then pulses start.
// PARAMETERS
//   CLK_DIV     4   clk cycles per sclk half-period (>=1)
//   SHIFT_BITS  16  bits per transfer, MSB first (<=24)
//   CS_GAP      2   clk cycles cs_n held high between transfers (>=1)
// PORTS
//   clk            in   1   system clock, all logic on rising edge
//   reset          in   1   synchronous, active-high reset
//   start          in   1   1-cycle pulse: begin pass at word 0 (ignored while busy)
//   abort          in   1   level: terminate sequence, return to IDLE
//   ram_address    out  5   setup RAM read address
//   ram_readdata   in   32  setup RAM data, valid 1 cycle after ram_address
//   ad_cs_n        out  1   A/D chip select, active low
//   ad_sclk        out  1   serial clock, idle low
//   ad_sdo         out  1   serial data to A/D
//   ad_sdi         in   1   serial data from A/D
//   busy           out  1   high from cycle after start until return to IDLE
//   done           out  1   1-cycle pulse at normal end of pass
//   word_index     out  5   index of word currently in transfer
//   result         out  SHIFT_BITS  bits captured in last transfer
//   result_valid   out  1   1-cycle pulse when result updates
// BEHAVIOUR
//   Reset: state IDLE, ram_address=0, ad_cs_n=1, ad_sclk=0, ad_sdo=0.
//     busy=0, done=0, word_index=0, result=0, result_valid=0.
//   Word format: [31] LAST, stop after this word. [30] SKIP, no transfer.
//     [SHIFT_BITS-1:0] tx data. All other bits ignored.
//   FSM: IDLE -> FETCH -> LOAD -> (SKIP? NEXT : CS_SETUP) -> SHIFT -> CS_HOLD -> GAP -> NEXT.
//   FETCH (1 cycle): ram_address = word_index.
//   LOAD (1 cycle): register ram_readdata into shift reg and flags.
//   Start latency: start sampled at edge k -> FETCH in k+1, LOAD in k+2, ad_cs_n low from k+3.
//   CS_SETUP: cs_n low, sclk low, sdo = tx MSB, for CLK_DIV cycles.
//   SHIFT: each bit is sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
//     ad_sdi is sampled in the cycle sclk goes 0->1.
//     sdo advances on the 1->0 edge.
//     Exactly SHIFT_BITS rising edges per transfer.
//   CS_HOLD: sclk low for CLK_DIV cycles. Then cs_n=1, result <= captured bits, result_valid pulses.
//   GAP: cs_n high for CS_GAP cycles.
//   NEXT (1 cycle):
//     LAST=1 or word_index==31: done pulses and FSM goes to IDLE, word_index=0. Word 31 is implicitly last.
//     Otherwise word_index+1 -> FETCH.
//   SKIP word: no cs_n activity, no result_valid. LAST still honoured.
//   abort=1 in any non-IDLE state: next cycle IDLE.
//     cs_n=1, sclk=0, busy=0, no done, no result_valid; word_index=0.
//   abort has priority over start in the same cycle.
//   start while busy: ignored, no queueing.
//   reset mid-transfer: all outputs to reset values on the next edge.
// CONFIGURATION
//   AD_SETUP_LOOP_EN defined:
//     at end of pass (LAST or word 31), done pulses and FSM continues to FETCH at word 0.
//     busy stays high; only abort or reset stops it.
//   Undefined: single pass as above; done then IDLE.
// TESTING
//   1. CLK_DIV=2, RAM[0]=0x8000_A5C3, sdi tied 1, start -> one cs_n low window.
//      16 sclk rising edges, sdo = A5C3 MSB first, result=0xFFFF.
//      result_valid 1 cycle, then done, busy=0.
//   2. RAM[0]=0x0000_1234, RAM[1]=0x4000_FFFF, RAM[2]=0x8000_0001 -> two transfers (1234, 0001).
//      word_index 0 then 2, no cs_n activity for word 1, one done.
//   3. RAM all 0x0000_0000, start -> 32 transfers, word_index 0..31, done after word 31, no wrap.
//   4. abort during 5th sclk of word 0 -> next cycle cs_n=1, sclk=0, busy=0.
//      No done, no result_valid; start again works from word 0.
//   5. start pulsed twice, 10 cycles apart, with RAM[0]=0x8000_00FF -> exactly one transfer, one done.
//   6. AD_SETUP_LOOP_EN, RAM[1] LAST -> words 0,1,0,1... with done each pass.
//      abort -> IDLE within 1 cycle.

Source files
------------

// File: rtl/ad_setup_sequencer.sv
// A/D setup sequencer: walks the 32-word setup RAM from word 0 and shifts each command out over SPI mode 0.
// Define AD_SETUP_LOOP_EN to restart at word 0 after every pass until abort or reset.
module ad_setup_sequencer #(
    parameter int CLK_DIV    = 4,
    parameter int SHIFT_BITS = 16,
    parameter int CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [4:0]            ram_address,
    input  logic [31:0]           ram_readdata,
    output logic                  ad_cs_n,
    output logic                  ad_sclk,
    output logic                  ad_sdo,
    input  logic                  ad_sdi,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            word_index,
    output logic [SHIFT_BITS-1:0] result,
    output logic                  result_valid
);

    localparam int MAX_CNT = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int BIT_W   = $clog2(SHIFT_BITS + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SHIFT_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_CS_SETUP,
        S_SHIFT,
        S_CS_HOLD,
        S_GAP,
        S_NEXT
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    sclk_q;
    logic                    cs_n_q;
    logic                    last_q;
    logic signed [SHIFT_BITS-1:0] tx_sh;
    logic [SHIFT_BITS-1:0]   rx_sh;
    logic [SHIFT_BITS-1:0]   rx_shifted;

    logic cnt_last;
    logic cnt_clr;
    logic sclk_nxt;
    logic load_en;
    logic sample_en;
    logic shift_en;
    logic bit_inc;
    logic result_en;
    logic wi_inc;
    logic wi_clr;
    logic done_nxt;

    // Bits 29..SHIFT_BITS of a setup word carry no meaning for the converter.
    logic unused_ram_bits;
    assign unused_ram_bits = ^ram_readdata[29:SHIFT_BITS];

    assign cnt_last = (state == S_GAP) ? (cnt == GAP_LAST) : (cnt == DIV_LAST);

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b1;
        sclk_nxt  = 1'b0;
        load_en   = 1'b0;
        sample_en = 1'b0;
        shift_en  = 1'b0;
        bit_inc   = 1'b0;
        result_en = 1'b0;
        wi_inc    = 1'b0;
        wi_clr    = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = S_LOAD;
            end
            S_LOAD: begin
                load_en   = 1'b1;
                state_nxt = ram_readdata[30] ? S_NEXT : S_CS_SETUP;
            end
            S_CS_SETUP: begin
                cnt_clr = 1'b0;
                if (cnt_last) begin
                    cnt_clr   = 1'b1;
                    sclk_nxt  = 1'b1;
                    sample_en = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                cnt_clr  = 1'b0;
                sclk_nxt = sclk_q;
                if (cnt_last) begin
                    cnt_clr = 1'b1;
                    if (sclk_q) begin
                        sclk_nxt = 1'b0;
                        shift_en = 1'b1;
                    end else if (bit_cnt == BIT_LAST) begin
                        state_nxt = S_CS_HOLD;
                    end else begin
                        sclk_nxt  = 1'b1;
                        sample_en = 1'b1;
                        bit_inc   = 1'b1;
                    end
                end
            end
            S_CS_HOLD: begin
                cnt_clr = 1'b0;
                if (cnt_last) begin
                    cnt_clr   = 1'b1;
                    result_en = 1'b1;
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                cnt_clr = 1'b0;
                if (cnt_last) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (last_q || (word_index == 5'd31)) begin
                    done_nxt = 1'b1;
                    wi_clr   = 1'b1;
`ifdef AD_SETUP_LOOP_EN
                    state_nxt = S_FETCH;
`else
                    state_nxt = S_IDLE;
`endif
                end else begin
                    wi_inc    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // abort wins over everything, including a start arriving in IDLE.
        if (abort) begin
            state_nxt = S_IDLE;
            cnt_clr   = 1'b1;
            sclk_nxt  = 1'b0;
            load_en   = 1'b0;
            sample_en = 1'b0;
            shift_en  = 1'b0;
            bit_inc   = 1'b0;
            result_en = 1'b0;
            wi_inc    = 1'b0;
            wi_clr    = 1'b1;
            done_nxt  = 1'b0;
        end
    end

    always_comb begin
        rx_shifted    = rx_sh << 1;
        rx_shifted[0] = ad_sdi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            sclk_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            last_q       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            word_index   <= '0;
            result       <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_clr ? '0 : cnt + CNT_W'(1);
            sclk_q       <= sclk_nxt;
            cs_n_q       <= !(state_nxt inside {S_CS_SETUP, S_SHIFT, S_CS_HOLD});
            busy         <= (state_nxt != S_IDLE);
            done         <= done_nxt;
            result_valid <= result_en;
            if (load_en) begin
                bit_cnt <= '0;
                last_q  <= ram_readdata[31];
            end else if (bit_inc) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (wi_clr) begin
                word_index <= '0;
            end else if (wi_inc) begin
                word_index <= word_index + 5'd1;
            end
            if (result_en) begin
                result <= rx_sh;
            end
        end
    end

    // Serial shift registers: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (load_en) begin
            tx_sh <= ram_readdata[SHIFT_BITS-1:0];
        end else if (shift_en) begin
            tx_sh <= tx_sh << 1;
        end
        if (sample_en) begin
            rx_sh <= rx_shifted;
        end
    end

    assign ram_address = word_index;
    assign ad_cs_n     = cs_n_q;
    assign ad_sclk     = sclk_q;
    assign ad_sdo      = ~cs_n_q & tx_sh[SHIFT_BITS-1];

endmodule

// File: tb/tb_ad_setup_sequencer.sv
// Bench for ad_setup_sequencer: RAM model, SPI slave/monitor and a transfer-list reference model.
`timescale 1ns/1ps
module tb_ad_setup_sequencer;

    localparam int CLK_DIV = 2;
    localparam int SB      = 16;
    localparam int CS_GAP  = 2;
    localparam int LIMIT   = 20000;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [4:0]    ram_address;
    logic [31:0]   ram_readdata;
    logic          ad_cs_n;
    logic          ad_sclk;
    logic          ad_sdo;
    logic          ad_sdi;
    logic          busy;
    logic          done;
    logic [4:0]    word_index;
    logic [SB-1:0] result;
    logic          result_valid;

    logic [31:0] mem [32];

    int n_checks = 0;
    int n_fail   = 0;

    ad_setup_sequencer #(
        .CLK_DIV   (CLK_DIV),
        .SHIFT_BITS(SB),
        .CS_GAP    (CS_GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .ram_address (ram_address),
        .ram_readdata(ram_readdata),
        .ad_cs_n     (ad_cs_n),
        .ad_sclk     (ad_sclk),
        .ad_sdo      (ad_sdo),
        .ad_sdi      (ad_sdi),
        .busy        (busy),
        .done        (done),
        .word_index  (word_index),
        .result      (result),
        .result_valid(result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Setup RAM: registered address, one cycle of read latency.
    always @(posedge clk) ram_readdata <= mem[ram_address];

    // SPI mode-0 slave and bus monitor, evaluated away from the active edge.
    logic          prev_cs   = 1'b1;
    logic          prev_sclk = 1'b0;
    logic [4:0]    cur_wi;
    logic [SB-1:0] cur_tx;
    logic [SB-1:0] rx_word;
    int            cur_edges = 0;
    int            bit_idx   = 0;
    int            done_cnt  = 0;
    int            sclk_outside = 0;
    bit            tie_one   = 1'b0;
    int            obs_wi[$];
    int            obs_edges[$];
    logic [SB-1:0] obs_tx[$];
    logic [SB-1:0] obs_res[$];
    logic [SB-1:0] sent_rx[$];

    always @(negedge clk) begin
        if (prev_cs && !ad_cs_n) begin
            cur_wi    = word_index;
            cur_tx    = '0;
            cur_edges = 0;
            rx_word   = tie_one ? {SB{1'b1}} : SB'($urandom);
            sent_rx.push_back(rx_word);
            ad_sdi    = rx_word[SB-1];
            bit_idx   = SB - 2;
        end else if (!ad_cs_n && prev_sclk && !ad_sclk) begin
            if (bit_idx >= 0) begin
                ad_sdi  = rx_word[bit_idx];
                bit_idx = bit_idx - 1;
            end
        end
        if (!ad_cs_n && ad_sclk && !prev_sclk) begin
            cur_tx    = {cur_tx[SB-2:0], ad_sdo};
            cur_edges = cur_edges + 1;
        end
        if (ad_cs_n && ad_sclk) sclk_outside = sclk_outside + 1;
        if (!prev_cs && ad_cs_n) begin
            obs_wi.push_back(int'(cur_wi));
            obs_tx.push_back(cur_tx);
            obs_edges.push_back(cur_edges);
        end
        if (result_valid) obs_res.push_back(result);
        if (done) done_cnt = done_cnt + 1;
        prev_cs   = ad_cs_n;
        prev_sclk = ad_sclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  32'(ram_address), 32'd0);
        check({tag, "_cs_n"},  32'(ad_cs_n), 32'd1);
        check({tag, "_sclk"},  32'(ad_sclk), 32'd0);
        check({tag, "_sdo"},   32'(ad_sdo), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_wi"},    32'(word_index), 32'd0);
        check({tag, "_res"},   32'(result), 32'd0);
        check({tag, "_rv"},    32'(result_valid), 32'd0);
    endtask

    // Bounded wait until the current transfer has produced n rising sclk edges.
    task automatic wait_edges(input string tag, input int n);
        int cyc;
        cyc = 0;
        while (ad_cs_n && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        while (cur_edges < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200 && cur_edges < n) check({tag, "_wait_timeout"}, 32'(cur_edges), 32'(n));
    endtask

    task automatic run_pass(input string tag, input int restart_after);
        int            exp_wi[$];
        logic [SB-1:0] exp_tx[$];
        int            obs_base, res_base, rx_base, done_base, outside_base;
        int            cyc, first_cs, n_obs, n_res;

        for (int i = 0; i < 32; i++) begin
            if (!mem[i][30]) begin
                exp_wi.push_back(i);
                exp_tx.push_back(mem[i][SB-1:0]);
            end
            if (mem[i][31]) break;
        end

        obs_base     = obs_wi.size();
        res_base     = obs_res.size();
        rx_base      = sent_rx.size();
        done_base    = done_cnt;
        outside_base = sclk_outside;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        first_cs = ad_cs_n ? -1 : 1;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        while (busy && cyc < LIMIT) begin
            if (cyc == restart_after) start = 1'b1;
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (first_cs < 0 && !ad_cs_n) first_cs = cyc;
        end
        check({tag, "_finished"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);

        if (!mem[0][30]) check({tag, "_cs_latency"}, 32'(first_cs), 32'd3);
        n_obs = obs_wi.size() - obs_base;
        n_res = obs_res.size() - res_base;
        check({tag, "_n_transfers"}, 32'(n_obs), 32'(exp_wi.size()));
        check({tag, "_n_result_valid"}, 32'(n_res), 32'(exp_wi.size()));
        check({tag, "_n_done"}, 32'(done_cnt - done_base), 32'd1);
        check({tag, "_sclk_outside_cs"}, 32'(sclk_outside - outside_base), 32'd0);
        for (int i = 0; i < exp_wi.size() && i < n_obs; i++) begin
            check($sformatf("%s_wi%0d", tag, i), 32'(obs_wi[obs_base + i]), 32'(exp_wi[i]));
            check($sformatf("%s_tx%0d", tag, i), 32'(obs_tx[obs_base + i]), 32'(exp_tx[i]));
            check($sformatf("%s_edges%0d", tag, i), 32'(obs_edges[obs_base + i]), 32'(SB));
            if (i < n_res && rx_base + i < sent_rx.size())
                check($sformatf("%s_res%0d", tag, i), 32'(obs_res[res_base + i]), 32'(sent_rx[rx_base + i]));
        end
        check({tag, "_wi_idle"}, 32'(word_index), 32'd0);
    endtask

    task automatic fill_random(input bit allow_last);
        for (int i = 0; i < 32; i++) begin
            mem[i] = {(allow_last && $urandom_range(7) == 0), ($urandom_range(3) == 0), 14'($urandom), 16'($urandom)};
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_rv, base_done;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

`ifdef AD_SETUP_LOOP_EN
        mem[0] = 32'h0000_1111;
        mem[1] = 32'h8000_2222;
        base_done = done_cnt;
        begin
            int n0, cyc;
            n0 = obs_wi.size();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc = 0;
            while (done_cnt - base_done < 3 && cyc < LIMIT) begin
                @(negedge clk);
                cyc++;
            end
            check("loop_three_passes", 32'(done_cnt - base_done >= 3), 32'd1);
            check("loop_busy_held", 32'(busy), 32'd1);
            for (int i = 0; i < 6 && n0 + i < obs_wi.size(); i++) begin
                check($sformatf("loop_wi%0d", i), 32'(obs_wi[n0 + i]), 32'(i % 2));
                check($sformatf("loop_tx%0d", i), 32'(obs_tx[n0 + i]), (i % 2) ? 32'h2222 : 32'h1111);
            end
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("loop_abort_busy", 32'(busy), 32'd0);
            check("loop_abort_cs_n", 32'(ad_cs_n), 32'd1);
            check("loop_abort_sclk", 32'(ad_sclk), 32'd0);
            check("loop_abort_wi", 32'(word_index), 32'd0);
        end
`else
        // Single word, LAST set, slave answering all ones.
        mem[0] = 32'h8000_A5C3;
        tie_one = 1'b1;
        run_pass("t1", 0);
        tie_one = 1'b0;
        check("t1_result_reg", 32'(result), 32'h0000_FFFF);

        // SKIP word in the middle.
        fill_random(1'b0);
        mem[0] = 32'h0000_1234;
        mem[1] = 32'h4000_FFFF;
        mem[2] = 32'h8000_0001;
        run_pass("t2", 0);

        // No LAST anywhere: word 31 ends the pass.
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        run_pass("t3", 0);

        // abort during the 5th sclk of word 0.
        mem[0] = 32'h0000_ABCD;
        mem[1] = 32'h8000_1357;
        base_rv   = obs_res.size();
        base_done = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_edges("t4", 5);
        check("t4_sclk_high_before_abort", 32'(ad_sclk), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_abort_cs_n", 32'(ad_cs_n), 32'd1);
        check("t4_abort_sclk", 32'(ad_sclk), 32'd0);
        check("t4_abort_busy", 32'(busy), 32'd0);
        check("t4_abort_wi", 32'(word_index), 32'd0);
        repeat (10) @(negedge clk);
        check("t4_no_result_valid", 32'(obs_res.size() - base_rv), 32'd0);
        check("t4_no_done", 32'(done_cnt - base_done), 32'd0);
        check("t4_still_idle", 32'(busy), 32'd0);
        run_pass("t4_restart", 0);

        // Second start while busy is ignored.
        mem[0] = 32'h8000_00FF;
        run_pass("t5", 10);

        // Reset in the middle of a transfer.
        mem[0] = 32'h0000_5A5A;
        mem[1] = 32'h8000_C3C3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_edges("t_rst", 3);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // abort and start together in IDLE: abort wins.
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_over_start_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Randomised RAM images.
        for (int r = 0; r < 6; r++) begin
            fill_random(r != 0);
            run_pass($sformatf("rnd%0d", r), (r == 3) ? 40 : 0);
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
